conv_layer_scheduler: RTL and testbench
=======================================

// Module: conv_layer_scheduler
// PURPOSE
//  Sequences one convolution layer on the IFM/weight BRAM + PE-cluster + ReLU6 datapath.
//  Loads IFM words, then packs 16-lane weight rows into the weight BRAMs, raises cal_start, and waits for done_compute.
//  Counts completed windows and reports layer completion.
//  Sits between the host/DMA load stream and the convolution sub-top.
// PARAMETERS
//  NUM_PE      16    weight banks / PE lanes per row
//  DATA_W      32    word width of the load stream and of each BRAM lane
//  ADDR_W      32    BRAM word-address width
//  CNT_W       20    width of the word/row counters
//  WDOG_CYCLES 4096  compute idle timeout in cycles (used only with CONV_SCHED_WDOG_EN)
// PORTS
//  clk            in   1             clock, rising edge
//  reset          in   1             asynchronous, active-high reset
//  start          in   1             layer start pulse; sampled only in IDLE
//  abort          in   1             synchronous abort; returns to IDLE from any state
//  ifm_words      in   CNT_W         IFM words to load; latched at start
//  w_rows         in   CNT_W         weight rows to load (one row = NUM_PE words); latched at start
//  ld_valid       in   1             load-stream word valid
//  ld_ready       out  1             load-stream ready
//  ld_data        in   DATA_W        load-stream word
//  wr_addr        out  ADDR_W        BRAM write address (word units)
//  wr_rd_en_IFM   out  1             IFM BRAM write strobe
//  data_in_IFM    out  DATA_W        IFM BRAM write data
//  wr_rd_en_Weight out 1             strobe writing all NUM_PE weight BRAMs at wr_addr
//  data_in_Weight out  NUM_PE*DATA_W packed row; lane k drives bank k
//  cal_start      out  1             compute enable to the address generator
//  done_window    in   1             one-cycle pulse per completed output window
//  done_compute   in   1             level/pulse: layer compute finished
//  busy           out  1             high in any state other than IDLE
//  layer_done     out  1             one-cycle pulse on normal completion
//  window_cnt     out  16            done_window pulses counted in current layer
//  err            out  1             watchdog error flag
// BEHAVIOUR
//  - All outputs are registered. Reset value of every output is 0. State resets to IDLE.
//  - States: IDLE, LOAD_IFM, LOAD_W, COMPUTE, DONE (plus ERR with the macro).
//  - IDLE, start=1:
//      latch ifm_words and w_rows; clear window_cnt and the address counter.
//      Next state is LOAD_IFM, or LOAD_W if ifm_words==0, or COMPUTE if both counts are 0.
//  - LOAD_IFM: ld_ready=1. Each handshake (ld_valid&&ld_ready) produces, next cycle:
//      wr_rd_en_IFM=1 (single cycle), data_in_IFM=ld_data, wr_addr=word index (0,1,2,...).
//      After the ifm_words-th handshake: go to LOAD_W and reset the address counter.
//  - LOAD_W: ld_ready=1. Handshaked words fill lanes 0..NUM_PE-1 in order.
//      On the NUM_PE-th word, next cycle: wr_rd_en_Weight=1 for 1 cycle, data_in_Weight=full row, wr_addr=row index.
//      Lane 0 of the next row is accepted in that same cycle with no bubble.
//      After the w_rows-th row write: go to COMPUTE.
//  - COMPUTE: ld_ready=0, both write strobes 0, cal_start=1 from the first COMPUTE cycle.
//      Each done_window pulse increments window_cnt, saturating at 16'hFFFF.
//      done_compute=1 -> DONE. A done_window in the same cycle is still counted.
//  - DONE: cal_start=0, layer_done=1 for one cycle, then -> IDLE. window_cnt holds until the next start.
//  - start while busy is ignored.
//  - ld_valid outside the load states is ignored.
//  - abort: next state IDLE; strobes, cal_start and ld_ready drop next cycle; no layer_done; partial weight row discarded.
//  - If abort and a handshake occur in the same cycle, abort wins and no write is issued.
//  - reset mid-operation: immediate return to IDLE, all outputs 0.
// CONFIGURATION
//  - CONV_SCHED_WDOG_EN defined:
//      An idle counter runs in COMPUTE and clears on each done_window.
//      Reaching WDOG_CYCLES -> ERR: cal_start=0, err=1, busy=1.
//      ERR -> IDLE on abort or start; err clears on leaving ERR.
//  - Not defined: no counter, err tied to 0, ERR state absent, COMPUTE waits indefinitely.
// STRUCTURE
//  - Package conv_sched_pkg: state enum sched_state_t; constants NUM_PE and DATA_W; typedef w_row_t (NUM_PE x DATA_W packed).
//  - Sub-module weight_row_packer: lane index, staging registers and row-complete pulse; cleared by abort or reset.
//  - The FSM and counters stay in conv_layer_scheduler.
// TESTING
//  - Load IFM: start, ifm_words=4, w_rows=0, 4 back-to-back words A0..A3
//      -> wr_rd_en_IFM pulses at addr 0..3 with matching data, then cal_start=1.
//  - Pack weights: w_rows=2, 32 words with gaps on ld_valid
//      -> exactly 2 wr_rd_en_Weight strobes, addr 0 then 1, lane k = word 16*row+k.
//  - Compute: 9 done_window pulses, done_compute on the 9th pulse
//      -> window_cnt=9, layer_done exactly one cycle, busy=0 next cycle.
//  - Abort at lane 7 of row 1
//      -> no weight strobe for row 1, IDLE; a new start reloads from addr 0.
//  - Zero counts: ifm_words=0, w_rows=0 -> COMPUTE entered 1 cycle after start; start during COMPUTE ignored.
//  - WDOG (macro on, WDOG_CYCLES=16): no done_window for 16 cycles -> err=1, cal_start=0; abort clears.

Source files
------------

// File: rtl/conv_sched_pkg.sv
// Shared types and constants for the convolution layer scheduler.
// ST_ERR exists only when CONV_SCHED_WDOG_EN is defined.
package conv_sched_pkg;

    localparam int unsigned NUM_PE = 16;
    localparam int unsigned DATA_W = 32;

    typedef logic [NUM_PE*DATA_W-1:0] w_row_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_IFM = 3'd1,
        ST_LOAD_W   = 3'd2,
        ST_COMPUTE  = 3'd3,
        ST_DONE     = 3'd4
`ifdef CONV_SCHED_WDOG_EN
        ,
        ST_ERR      = 3'd5
`endif
    } sched_state_t;

endpackage

// File: rtl/weight_row_packer.sv
// Collects NUM_PE consecutive load words into one weight row.
// The completed row and its pulse are combinational so the caller can register them.
module weight_row_packer #(
    parameter int unsigned NUM_PE = 16,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [DATA_W-1:0]        data,
    output logic                     row_done,
    output logic [NUM_PE*DATA_W-1:0] row_data
);

    localparam int unsigned LANE_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    logic [LANE_W-1:0] lane;
    logic [DATA_W-1:0] stage [NUM_PE];
    logic              last_lane;

    assign last_lane = (lane == LANE_W'(NUM_PE - 1));
    assign row_done  = push && last_lane;

    // The final lane comes straight from the input word, not from staging.
    always_comb begin
        row_data = '0;
        for (int unsigned k = 0; k < NUM_PE; k++) begin
            row_data[k*DATA_W +: DATA_W] = (LANE_W'(k) == lane) ? data : stage[k];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane <= '0;
            for (int unsigned k = 0; k < NUM_PE; k++) begin
                stage[k] <= '0;
            end
        end else if (clear) begin
            lane <= '0;
        end else if (push) begin
            stage[lane] <= data;
            lane        <= last_lane ? '0 : lane + 1'b1;
        end
    end

endmodule

// File: rtl/conv_layer_scheduler.sv
// Sequences one convolution layer: IFM load, weight-row load, compute, completion.
// Define CONV_SCHED_WDOG_EN to enable the compute idle watchdog and the ERR state.
module conv_layer_scheduler #(
    parameter int unsigned NUM_PE      = 16,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned CNT_W       = 20,
    parameter int unsigned WDOG_CYCLES = 4096
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [CNT_W-1:0]         ifm_words,
    input  logic [CNT_W-1:0]         w_rows,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [DATA_W-1:0]        ld_data,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic                     wr_rd_en_IFM,
    output logic [DATA_W-1:0]        data_in_IFM,
    output logic                     wr_rd_en_Weight,
    output logic [NUM_PE*DATA_W-1:0] data_in_Weight,
    output logic                     cal_start,
    input  logic                     done_window,
    input  logic                     done_compute,
    output logic                     busy,
    output logic                     layer_done,
    output logic [15:0]              window_cnt,
    output logic                     err
);

    import conv_sched_pkg::*;

    sched_state_t            state;
    sched_state_t            state_nxt;
    logic [CNT_W-1:0]        ifm_lat;
    logic [CNT_W-1:0]        w_lat;
    logic [CNT_W-1:0]        item_cnt;
    logic [CNT_W-1:0]        item_nxt;
    logic                    hs;
    logic                    row_done;
    logic [NUM_PE*DATA_W-1:0] row_data;

`ifdef CONV_SCHED_WDOG_EN
    localparam int unsigned IDLE_W = $clog2(WDOG_CYCLES + 1);
    logic [IDLE_W-1:0] idle_cnt;
`endif

    // Abort suppresses the handshake so a colliding word is never written.
    assign hs       = ld_valid && ld_ready && !abort
                      && ((state == ST_LOAD_IFM) || (state == ST_LOAD_W));
    assign item_nxt = item_cnt + 1'b1;

    weight_row_packer #(
        .NUM_PE (NUM_PE),
        .DATA_W (DATA_W)
    ) u_packer (
        .clk      (clk),
        .reset    (reset),
        .clear    (abort || (state != ST_LOAD_W)),
        .push     (hs && (state == ST_LOAD_W)),
        .data     (ld_data),
        .row_done (row_done),
        .row_data (row_data)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (ifm_words != '0)   state_nxt = ST_LOAD_IFM;
                    else if (w_rows != '0) state_nxt = ST_LOAD_W;
                    else                   state_nxt = ST_COMPUTE;
                end
            end
            ST_LOAD_IFM: begin
                if (hs && (item_nxt == ifm_lat))
                    state_nxt = (w_lat != '0) ? ST_LOAD_W : ST_COMPUTE;
            end
            ST_LOAD_W: begin
                if (row_done && (item_nxt == w_lat)) state_nxt = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                if (done_compute) state_nxt = ST_DONE;
`ifdef CONV_SCHED_WDOG_EN
                else if (!done_window && (idle_cnt == IDLE_W'(WDOG_CYCLES - 1)))
                    state_nxt = ST_ERR;
`endif
            end
            ST_DONE: state_nxt = ST_IDLE;
`ifdef CONV_SCHED_WDOG_EN
            ST_ERR: begin
                if (start) state_nxt = ST_IDLE;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
        if (abort) state_nxt = ST_IDLE;
    end

    // Status outputs are registered from the next state so they align with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            ifm_lat         <= '0;
            w_lat           <= '0;
            item_cnt        <= '0;
            ld_ready        <= 1'b0;
            wr_addr         <= '0;
            wr_rd_en_IFM    <= 1'b0;
            data_in_IFM     <= '0;
            wr_rd_en_Weight <= 1'b0;
            data_in_Weight  <= '0;
            cal_start       <= 1'b0;
            busy            <= 1'b0;
            layer_done      <= 1'b0;
            window_cnt      <= '0;
        end else begin
            state           <= state_nxt;
            ld_ready        <= (state_nxt == ST_LOAD_IFM) || (state_nxt == ST_LOAD_W);
            cal_start       <= (state_nxt == ST_COMPUTE);
            busy            <= (state_nxt != ST_IDLE);
            layer_done      <= (state_nxt == ST_DONE);
            wr_rd_en_IFM    <= 1'b0;
            wr_rd_en_Weight <= 1'b0;

            if ((state == ST_IDLE) && start && !abort) begin
                ifm_lat    <= ifm_words;
                w_lat      <= w_rows;
                item_cnt   <= '0;
                window_cnt <= '0;
            end

            if ((state == ST_LOAD_IFM) && hs) begin
                wr_rd_en_IFM <= 1'b1;
                data_in_IFM  <= ld_data;
                wr_addr      <= ADDR_W'(item_cnt);
                item_cnt     <= (item_nxt == ifm_lat) ? '0 : item_nxt;
            end

            if ((state == ST_LOAD_W) && row_done) begin
                wr_rd_en_Weight <= 1'b1;
                data_in_Weight  <= row_data;
                wr_addr         <= ADDR_W'(item_cnt);
                item_cnt        <= item_nxt;
            end

            if ((state == ST_COMPUTE) && done_window && (window_cnt != '1))
                window_cnt <= window_cnt + 16'd1;
        end
    end

`ifdef CONV_SCHED_WDOG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
            err      <= 1'b0;
        end else begin
            err <= (state_nxt == ST_ERR);
            if ((state == ST_COMPUTE) && !done_window) idle_cnt <= idle_cnt + 1'b1;
            else                                       idle_cnt <= '0;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Directed-random bench for conv_layer_scheduler against expected write lists built from the load words.
// Watchdog section runs only when CONV_SCHED_WDOG_EN is defined.
`timescale 1ns/1ps
module tb_conv_layer_scheduler;

    localparam int unsigned NPE = 16;
    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 32;
    localparam int unsigned CW  = 20;

    logic              clk = 1'b0;
    logic              reset, start, abort, ld_valid, done_window, done_compute;
    logic [CW-1:0]     ifm_words, w_rows;
    logic [DW-1:0]     ld_data;
    logic              ld_ready, wr_rd_en_IFM, wr_rd_en_Weight, cal_start, busy, layer_done, err;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     data_in_IFM;
    logic [NPE*DW-1:0] data_in_Weight;
    logic [15:0]       window_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conv_layer_scheduler #(
        .NUM_PE      (NPE),
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .CNT_W       (CW),
        .WDOG_CYCLES (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .abort           (abort),
        .ifm_words       (ifm_words),
        .w_rows          (w_rows),
        .ld_valid        (ld_valid),
        .ld_ready        (ld_ready),
        .ld_data         (ld_data),
        .wr_addr         (wr_addr),
        .wr_rd_en_IFM    (wr_rd_en_IFM),
        .data_in_IFM     (data_in_IFM),
        .wr_rd_en_Weight (wr_rd_en_Weight),
        .data_in_Weight  (data_in_Weight),
        .cal_start       (cal_start),
        .done_window     (done_window),
        .done_compute    (done_compute),
        .busy            (busy),
        .layer_done      (layer_done),
        .window_cnt      (window_cnt),
        .err             (err)
    );

    // Write/pulse observer, sampled mid-cycle.
    logic [AW-1:0]     ifm_addr_q[$];
    logic [DW-1:0]     ifm_data_q[$];
    logic [AW-1:0]     w_addr_q[$];
    logic [NPE*DW-1:0] w_row_q[$];
    int                ld_pulses = 0;

    always @(negedge clk) begin
        if (wr_rd_en_IFM === 1'b1) begin
            ifm_addr_q.push_back(wr_addr);
            ifm_data_q.push_back(data_in_IFM);
        end
        if (wr_rd_en_Weight === 1'b1) begin
            w_addr_q.push_back(wr_addr);
            w_row_q.push_back(data_in_Weight);
        end
        if (layer_done === 1'b1) ld_pulses++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [NPE*DW-1:0] obs, input logic [NPE*DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        ifm_addr_q.delete();
        ifm_data_q.delete();
        w_addr_q.delete();
        w_row_q.delete();
    endtask

    task automatic pulse_start(input int unsigned nifm, input int unsigned nrows);
        ifm_words = CW'(nifm);
        w_rows    = CW'(nrows);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Offers one word after `gap` idle cycles; `stalls` counts cycles spent waiting for ready.
    task automatic send_word(input logic [DW-1:0] w, input int unsigned gap, output int unsigned stalls);
        ld_valid = 1'b0;
        repeat (gap) tick();
        ld_valid = 1'b1;
        ld_data  = w;
        stalls   = 0;
        while (ld_ready !== 1'b1 && stalls < 20) begin
            tick();
            stalls++;
        end
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic finish_layer();
        done_compute = 1'b1;
        tick();
        done_compute = 1'b0;
        tick();
    endtask

    function automatic logic [NPE*DW-1:0] build_row(input logic [DW-1:0] words[$], input int unsigned r);
        logic [NPE*DW-1:0] row;
        row = '0;
        for (int unsigned k = 0; k < NPE; k++) row[k*DW +: DW] = words[NPE*r + k];
        return row;
    endfunction

    initial begin
        logic [DW-1:0] words[$];
        int unsigned   st;
        int unsigned   stall_sum;
        int unsigned   nwin;
        int            ld_before;

        reset = 1'b1; start = 1'b0; abort = 1'b0; ld_valid = 1'b0; ld_data = '0;
        done_window = 1'b0; done_compute = 1'b0; ifm_words = '0; w_rows = '0;
        #2;
        chk("reset_busy", busy, 0);
        chk("reset_ld_ready", ld_ready, 0);
        chk("reset_cal_start", cal_start, 0);
        chk("reset_wr_addr", wr_addr, 0);
        chk("reset_window_cnt", window_cnt, 0);
        chk("reset_err", err, 0);
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Layer 1: four back-to-back IFM words, no weights.
        clear_obs();
        words.delete();
        for (int i = 0; i < 4; i++) words.push_back($urandom);
        pulse_start(4, 0);
        chk("l1_ld_ready_after_start", ld_ready, 1);
        chk("l1_busy_after_start", busy, 1);
        stall_sum = 0;
        for (int i = 0; i < 4; i++) begin
            send_word(words[i], 0, st);
            stall_sum += st;
        end
        chk("l1_cal_start", cal_start, 1);
        chk("l1_ld_ready_compute", ld_ready, 0);
        tick();
        chk("l1_stalls", stall_sum, 0);
        chk("l1_ifm_count", ifm_addr_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("l1_ifm_addr%0d", i), ifm_addr_q[i], i);
            chk($sformatf("l1_ifm_data%0d", i), ifm_data_q[i], words[i]);
        end
        chk("l1_no_weight_write", w_addr_q.size(), 0);

        // Nine windows, done_compute together with the ninth.
        for (int i = 0; i < 9; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            done_window  = 1'b1;
            done_compute = (i == 8);
            tick();
            done_window  = 1'b0;
            done_compute = 1'b0;
        end
        chk("l1_window_cnt", window_cnt, 9);
        chk("l1_layer_done", layer_done, 1);
        chk("l1_cal_start_done", cal_start, 0);
        tick();
        chk("l1_layer_done_drop", layer_done, 0);
        chk("l1_busy_idle", busy, 0);
        chk("l1_window_hold", window_cnt, 9);
        chk("l1_layer_done_pulses", ld_pulses, 1);

        // Layer 2: two weight rows with ld_valid gaps; no gap across the row boundary.
        clear_obs();
        words.delete();
        for (int i = 0; i < 2 * NPE; i++) words.push_back($urandom);
        pulse_start(0, 2);
        chk("l2_window_cleared", window_cnt, 0);
        chk("l2_ld_ready", ld_ready, 1);
        stall_sum = 0;
        for (int i = 0; i < 2 * NPE; i++) begin
            send_word(words[i], (i == NPE) ? 0 : $urandom_range(0, 2), st);
            stall_sum += st;
        end
        chk("l2_cal_start", cal_start, 1);
        tick();
        chk("l2_stalls", stall_sum, 0);
        chk("l2_w_count", w_addr_q.size(), 2);
        for (int unsigned r = 0; r < 2; r++) begin
            chk($sformatf("l2_w_addr%0d", r), w_addr_q[r], r);
            chk($sformatf("l2_w_row%0d", r), w_row_q[r], build_row(words, r));
        end
        chk("l2_no_ifm_write", ifm_addr_q.size(), 0);
        finish_layer();
        chk("l2_idle", busy, 0);

        // Layer 3: abort arriving with lane 7 of row 1.
        clear_obs();
        words.delete();
        for (int i = 0; i < 2 + NPE + 8; i++) words.push_back($urandom);
        ld_before = ld_pulses;
        pulse_start(2, 2);
        for (int i = 0; i < 2 + NPE + 7; i++) send_word(words[i], $urandom_range(0, 1), st);
        ld_valid = 1'b1;
        ld_data  = words[2 + NPE + 7];
        abort    = 1'b1;
        tick();
        abort    = 1'b0;
        ld_valid = 1'b0;
        chk("l3_abort_busy", busy, 0);
        chk("l3_abort_ld_ready", ld_ready, 0);
        chk("l3_abort_cal_start", cal_start, 0);
        repeat (3) tick();
        chk("l3_w_count", w_addr_q.size(), 1);
        chk("l3_ifm_count", ifm_addr_q.size(), 2);
        words = words[2:$];
        chk("l3_w_row0", w_row_q[0], build_row(words, 0));
        chk("l3_no_layer_done", ld_pulses, ld_before);

        // Restart after abort: addresses and lanes begin again from zero.
        clear_obs();
        words.delete();
        for (int i = 0; i < 1 + NPE; i++) words.push_back($urandom);
        pulse_start(1, 1);
        for (int i = 0; i < 1 + NPE; i++) send_word(words[i], $urandom_range(0, 2), st);
        tick();
        chk("l3b_ifm_addr", ifm_addr_q[0], 0);
        chk("l3b_ifm_data", ifm_data_q[0], words[0]);
        chk("l3b_w_count", w_addr_q.size(), 1);
        chk("l3b_w_addr", w_addr_q[0], 0);
        words = words[1:$];
        chk("l3b_w_row", w_row_q[0], build_row(words, 0));
        finish_layer();

        // Layer 4: zero counts; start and ld_valid during COMPUTE are ignored.
        clear_obs();
        pulse_start(0, 0);
        chk("l4_cal_start_first", cal_start, 1);
        chk("l4_ld_ready", ld_ready, 0);
        pulse_start(5, 1);
        ld_valid = 1'b1;
        ld_data  = $urandom;
        repeat (2) tick();
        ld_valid = 1'b0;
        chk("l4_still_compute", cal_start, 1);
        chk("l4_busy", busy, 1);
        chk("l4_no_writes", ifm_addr_q.size() + w_addr_q.size(), 0);
        nwin = $urandom_range(1, 5);
        for (int unsigned i = 0; i < nwin; i++) begin
            done_window = 1'b1;
            tick();
            done_window = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        chk("l4_window_cnt", window_cnt, nwin);
        finish_layer();
        chk("l4_idle", busy, 0);
        chk("l4_err_clear", err, 0);

`ifdef CONV_SCHED_WDOG_EN
        // Watchdog: sixteen compute cycles without a window trips ERR.
        pulse_start(0, 0);
        repeat (15) tick();
        chk("wdog_not_yet", err, 0);
        tick();
        chk("wdog_err", err, 1);
        chk("wdog_cal_start", cal_start, 0);
        chk("wdog_busy", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("wdog_err_cleared", err, 0);
        chk("wdog_idle", busy, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
